sha256_msg_sched: RTL and testbench



---
 rtl/sha256_msg_sched.sv | 131 +++++++++++++
 tb/tb_sha256_msg_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 block words serially, then emits W_0..W_{NUM_WORDS-1}.
// Optional macro SHA256_MSG_SCHED_BLKCNT_EN adds a completed-block counter output blk_cnt.
module sha256_msg_sched #(
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last,
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
  output logic [31:0] blk_cnt,
`endif
  output logic        busy
);

  // state    | meaning
  // S_LOAD   | t = 0..15, passing input words through and filling the window
  // S_EXPAND | t = 16..NUM_WORDS-1, generating words from the window
  typedef enum logic {S_LOAD = 1'b0, S_EXPAND = 1'b1} state_e;

  localparam logic [6:0] T_END    = 7'(NUM_WORDS);
  localparam logic [5:0] IDX_LAST = 6'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [15:0][31:0] win_q;
  logic [31:0]       out_word_q;
  logic [5:0]        out_idx_q;
  logic              out_valid_q;
  logic              busy_q;

  logic        adv;
  logic        load_fire;
  logic        exp_fire;
  logic        last_take;
  logic [31:0] exp_word;
  logic [31:0] new_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign adv       = !out_valid_q || out_ready;
  assign out_last  = out_valid_q && (out_idx_q == IDX_LAST);
  assign last_take = out_last && out_ready;
  assign exp_word  = sigma1(win_q[1]) + win_q[6] + sigma0(win_q[14]) + win_q[15];
  assign new_word  = (state_q == S_LOAD) ? in_word : exp_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // t parks at NUM_WORDS after the last word until that word is consumed.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    if (last_take) begin
      state_d = S_LOAD;
      t_d     = '0;
    end else if (load_fire || exp_fire) begin
      t_d = t_q + 7'd1;
      if (load_fire && (t_q == 7'd15)) state_d = S_EXPAND;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    load_fire = 1'b0;
    exp_fire  = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready  = adv && !rst;
        load_fire = adv && !rst && in_valid;
      end
      S_EXPAND: exp_fire = adv && (t_q < T_END);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (load_fire || exp_fire) begin
        out_word_q  <= new_word;
        out_idx_q   <= t_q[5:0];
        out_valid_q <= 1'b1;
        win_q       <= {win_q[14:0], new_word};
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (load_fire) busy_q <= 1'b1;
      else if (last_take) busy_q <= 1'b0;
    end
  end

`ifdef SHA256_MSG_SCHED_BLKCNT_EN
  logic [31:0] blk_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_cnt_q <= '0;
    else if (last_take) blk_cnt_q <= blk_cnt_q + 32'd1;
  end
  assign blk_cnt = blk_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: array-based schedule model, per-cycle output checker.
module tb_sha256_msg_sched;
  localparam int NW = 64;
  typedef logic [31:0] blk_t [16];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
  logic [31:0] blk_cnt;
  int          exp_blk = 0;
`endif

  sha256_msg_sched #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .out_last(out_last),
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    .blk_cnt(blk_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_last = 0;
  int          ready_mode = 0;
  logic [31:0] exp_w [$];
  int          exp_i [$];
  logic [31:0] got [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model_w(input blk_t m, input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    return w[t];
  endfunction

  // Consumer readiness: always 1, or the repeating pattern 1,0,0,1.
  initial begin
    bit [3:0] pat = 4'b1001;
    int cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (ready_mode == 0) ? 1'b1 : pat[cyc % 4];
    end
  end

  // Output checker, sampled on the falling edge.
  initial begin
    logic        stall_prev = 1'b0;
    logic [31:0] held_w = '0;
    logic [5:0]  held_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_word", out_word, held_w);
          chk("hold_idx", 32'(out_idx), 32'(held_i));
        end
        stall_prev = 1'b0;
        if (!out_valid) begin
          chk("last_idle", 32'(out_last), 32'd0);
        end else begin
          chk("last_flag", 32'(out_last), 32'(out_idx == 6'(NW - 1)));
          if (!out_ready) begin
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            held_w = out_word;
            held_i = out_idx;
            stall_prev = 1'b1;
          end else if (exp_w.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_word: got idx %0d word %h, want none", out_idx, out_word);
          end else begin
            chk("word", out_word, exp_w[0]);
            chk("idx", 32'(out_idx), 32'(exp_i[0]));
            void'(exp_w.pop_front());
            void'(exp_i.pop_front());
            got[out_idx] = out_word;
            if (out_last) begin
              n_last++;
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
              chk("blk_cnt", blk_cnt, 32'(exp_blk));
              exp_blk++;
`endif
            end
          end
        end
      end
    end
  end

  task automatic run_block(input blk_t m, input int gap_after);
    for (int t = 0; t < NW; t++) begin
      exp_w.push_back(model_w(m, t));
      exp_i.push_back(t);
    end
    for (int i = 0; i < 16; i++) begin
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_word  = m[i];
      for (int k = 0; k < 500 && !ok; k++) begin
        @(negedge clk);
        ok = in_ready;
      end
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 at word %0d, want 1", i);
      end
      @(posedge clk);
      #1;
      if (i == gap_after) begin
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = (exp_w.size() == 0) && !busy;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d words pending, want 0", exp_w.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_w.delete();
    exp_i.delete();
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    exp_blk = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    blk_t abc, zero, sig;
    bit   hit;
    abc  = '{default: 32'h0};
    zero = '{default: 32'h0};
    sig  = '{default: 32'h0};
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    sig[14] = 32'h80000000;

    chk("model_abc_w16", model_w(abc, 16), 32'h61626380);
    chk("model_abc_w17", model_w(abc, 17), 32'h000F0000);
    chk("model_abc_w18", model_w(abc, 18), 32'h7DA86405);
    chk("model_sig_w16", model_w(sig, 16), 32'h00205000);

    rst = 1'b1;
    in_valid = 1'b0;
    in_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    chk("rst_blk_cnt", blk_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // abc block at full rate
    run_block(abc, -1);
    wait_done();
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w18", got[18], 32'h7DA86405);
    chk("abc_n_last", 32'(n_last), 32'd1);
    chk("abc_busy_after", 32'(busy), 32'd0);

    // abc with consumer stalls
    ready_mode = 1;
    run_block(abc, -1);
    wait_done();
    ready_mode = 0;
    chk("stall_w18", got[18], 32'h7DA86405);
    chk("stall_n_last", 32'(n_last), 32'd2);

    // abc with an input gap after W5
    run_block(abc, 5);
    wait_done();
    chk("gap_w17", got[17], 32'h000F0000);

    // reset in the middle of expansion
    run_block(abc, -1);
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      hit = out_valid && (out_idx == 6'd30);
    end
    chk("reach_idx30", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_w.delete();
    exp_i.delete();
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    exp_blk = 0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk) chk("post_rst_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    run_block(abc, -1);
    wait_done();
    chk("after_rst_w18", got[18], 32'h7DA86405);

    // back-to-back blocks from a fresh reset
    do_reset();
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    chk("b2b_blk_cnt0", blk_cnt, 32'd0);
`endif
    run_block(zero, -1);
    run_block(abc, -1);
    wait_done();
    chk("b2b_w16", got[16], 32'h61626380);
`ifdef SHA256_MSG_SCHED_BLKCNT_EN
    chk("b2b_blk_cnt2", blk_cnt, 32'd2);
`endif

    // single high bit in W14 exercises sigma1
    run_block(sig, -1);
    wait_done();
    chk("sig_w16", got[16], 32'h00205000);
    chk("sig_w0", got[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
